ram_port_arbiter: RTL and testbench

- Shares the single-port 4096x32 data RAM between two requesters:
  - M0: the CPU load/store path.
  - M1: the SVD matrix loader/DMA.
- Round-robin arbitration, with optional bounded locked bursts.
- Fixed 1-cycle read latency.
- Sits between the requesters and the RAM array, and is the only block that drives RAM control.

---
 rtl/ram_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with bounded lock bursts that shares one single-port RAM between M0 and M1.
// Grants are combinational in the request cycle, and read data returns one cycle later.
module ram_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // last_q / lock_own_q: 0 = M0, 1 = M1
    logic              last_q, last_d;
    logic              lock_held_q, lock_held_d;
    logic              lock_own_q, lock_own_d;
    logic              idle_q, idle_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic gnt0, gnt1, gnt_any, win_lock;
    logic own_req, own_lock, oth_req, brk, hold;

    assign own_req  = lock_own_q ? m1_req  : m0_req;
    assign own_lock = lock_own_q ? m1_lock : m0_lock;
    assign oth_req  = lock_own_q ? m0_req  : m1_req;
    assign brk      = lock_held_q && (lock_cnt_q == CNT_MAX) && oth_req;
    // The owner may skip one cycle with lock still high without losing the RAM.
    assign hold     = lock_held_q && !brk && (own_req || (own_lock && !idle_q));

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            gnt0 = 1'b0;
        end else if (hold) begin
            gnt0 = own_req && !lock_own_q;
            gnt1 = own_req &&  lock_own_q;
        end else if (brk) begin
            gnt0 =  lock_own_q;
            gnt1 = !lock_own_q;
        end else if (m0_req && m1_req) begin
            gnt0 =  last_q;
            gnt1 = !last_q;
        end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
        end
    end

    assign gnt_any   = gnt0 | gnt1;
    assign win_lock  = gnt1 ? m1_lock : m0_lock;
    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign ram_en    = gnt_any;
    assign ram_we    = gnt1 ? m1_we    : (gnt0 & m0_we);
    assign ram_addr  = gnt1 ? m1_addr  : (gnt0 ? m0_addr  : '0);
    assign ram_wdata = gnt1 ? m1_wdata : (gnt0 ? m0_wdata : '0);

    assign m0_rvalid = rvalid_q[0] & ~rst;
    assign m1_rvalid = rvalid_q[1] & ~rst;
    assign m0_rdata  = m0_rvalid ? ram_rdata : rdata0_q;
    assign m1_rdata  = m1_rvalid ? ram_rdata : rdata1_q;
    assign busy      = ((|rvalid_q) | lock_held_q) & ~rst;

    always_comb begin
        last_d      = last_q;
        lock_held_d = lock_held_q;
        lock_own_d  = lock_own_q;
        idle_d      = idle_q;
        lock_cnt_d  = lock_cnt_q;
        if (gnt_any) begin
            last_d = gnt1;
            idle_d = 1'b0;
            if (win_lock) begin
                lock_held_d = 1'b1;
                lock_own_d  = gnt1;
                if (lock_held_q && (lock_own_q == gnt1)) begin
                    if (lock_cnt_q != CNT_MAX) lock_cnt_d = lock_cnt_q + CNT_ONE;
                end else begin
                    lock_cnt_d = CNT_ONE;
                end
            end else begin
                lock_held_d = 1'b0;
                lock_cnt_d  = '0;
            end
        end else if (lock_held_q && own_lock && !idle_q) begin
            idle_d = 1'b1;
        end else begin
            lock_held_d = 1'b0;
            lock_cnt_d  = '0;
            idle_d      = 1'b0;
        end
    end

    assign rvalid_d = {gnt1 & ~m1_we, gnt0 & ~m0_we};
    assign rdata0_d = rvalid_q[0] ? ram_rdata : rdata0_q;
    assign rdata1_d = rvalid_q[1] ? ram_rdata : rdata1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= 1'b1;
            lock_held_q <= 1'b0;
            lock_own_q  <= 1'b0;
            idle_q      <= 1'b0;
            lock_cnt_q  <= '0;
            rvalid_q    <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            last_q      <= last_d;
            lock_held_q <= lock_held_d;
            lock_own_q  <= lock_own_d;
            idle_q      <= idle_d;
            lock_cnt_q  <= lock_cnt_d;
            rvalid_q    <= rvalid_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: stimulus queues expected grants/read data, a negedge monitor checks them.
module tb_ram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [11:0] m0_addr, m1_addr, ram_addr;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_en, ram_we, busy;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_LOCK(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    // behavioural RAM with 1-cycle read latency
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
    end

    typedef struct packed {
        logic [1:0]  who;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
    } gexp_t;

    gexp_t       gq[$];
    logic [31:0] rq0[$];
    logic [31:0] rq1[$];
    int          n_chk = 0;
    int          n_pass = 0;
    gexp_t       mon_e;
    logic [1:0]  mon_who;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_who = {m1_gnt, m0_gnt};
            if (gq.size() != 0) begin
                mon_e = gq.pop_front();
                check("grant", {mon_who, ram_en, ram_we, ram_addr, ram_wdata},
                      {mon_e.who, (mon_e.who != 2'd0), mon_e.we, mon_e.addr, mon_e.wdata});
            end else if (ram_en || m0_gnt || m1_gnt) begin
                check("grant_unexpected", {62'd0, mon_who}, 64'd0);
            end
            if (m0_rvalid) begin
                if (rq0.size() != 0) check("m0_rdata", {32'd0, m0_rdata}, {32'd0, rq0.pop_front()});
                else check("m0_rvalid_unexpected", {63'd0, m0_rvalid}, 64'd0);
            end
            if (m1_rvalid) begin
                if (rq1.size() != 0) check("m1_rdata", {32'd0, m1_rdata}, {32'd0, rq1.pop_front()});
                else check("m1_rvalid_unexpected", {63'd0, m1_rvalid}, 64'd0);
            end
        end
    end

    // who: 0 = no grant, 1 = M0, 2 = M1
    task automatic cyc(input logic r0, input logic w0, input logic l0, input logic [11:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1, input logic l1,
                       input logic [11:0] a1, input logic [31:0] d1, input int who);
        gexp_t e;
        m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
        e = '0;
        if (who == 1) begin
            e.who = 2'd1; e.we = w0; e.addr = a0; e.wdata = d0;
        end else if (who == 2) begin
            e.who = 2'd2; e.we = w1; e.addr = a1; e.wdata = d1;
        end
        gq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 12'h0, 32'h0, 0, 0, 0, 12'h0, 32'h0, 0);
    endtask

    task automatic check_reset_outs(input string name);
        check(name, {m0_gnt, m1_gnt, ram_en, ram_we, m0_rvalid, m1_rvalid, busy, ram_addr, ram_wdata}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        m0_req = 1; m1_req = 1;
        #3 check_reset_outs("reset_outputs");
        @(posedge clk);
        #1;
        rst = 1'b0; m0_req = 0; m1_req = 0;

        // M0 alone: write then read back
        cyc(1, 1, 0, 12'h010, 32'hDEADBEEF, 0, 0, 0, 12'h0, 32'h0, 1);
        rq0.push_back(32'hDEADBEEF);
        cyc(1, 0, 0, 12'h010, 32'h0, 0, 0, 0, 12'h0, 32'h0, 1);
        idle(1);
        check("m0_rdata_hold", {32'd0, m0_rdata}, {32'd0, 32'hDEADBEEF});

        // both requesting from reset: strict alternation starting with M0
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rq0.push_back(32'hDEADBEEF);
        rq0.push_back(32'hDEADBEEF);
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 0, 12'h010, 32'h0, 1, 1, 0, 12'h200, 32'h55, (i % 2 == 0) ? 1 : 2);
        idle(1);

        // M1 locked read burst of 20, M0 idle
        for (int i = 0; i < 20; i++) begin
            rq1.push_back(32'h55);
            cyc(0, 0, 0, 12'h0, 32'h0, 1, 0, 1, 12'h200, 32'h0, 2);
        end
        idle(1);

        // second locked burst: M0 gets in after exactly 8 M1 grants
        cyc(0, 0, 0, 12'h0, 32'h0, 1, 1, 1, 12'h300, 32'h300, 2);
        for (int i = 1; i < 8; i++)
            cyc(1, 1, 0, 12'h301, 32'hA5A5, 1, 1, 1, 12'h300 + 12'(i), 32'h300 + i, 2);
        cyc(1, 1, 0, 12'h301, 32'hA5A5, 1, 1, 1, 12'h308, 32'h308, 1);
        cyc(0, 0, 0, 12'h0, 32'h0, 1, 1, 1, 12'h308, 32'h308, 2);
        check("busy_lock_held", {63'd0, busy}, 64'd1);
        idle(1);
        check("busy_released", {63'd0, busy}, 64'd0);

        // same-address read (M0) vs write (M1) with M1 favoured
        rq0.push_back(32'hDEADBEEF);
        cyc(1, 0, 0, 12'h010, 32'h0, 0, 0, 0, 12'h0, 32'h0, 1);
        cyc(1, 0, 0, 12'h005, 32'h0, 1, 1, 0, 12'h005, 32'h1234, 2);
        rq0.push_back(32'h1234);
        cyc(1, 0, 0, 12'h005, 32'h0, 0, 0, 0, 12'h0, 32'h0, 1);
        idle(1);

        // reset right after a granted read drops its response
        cyc(1, 0, 0, 12'h010, 32'h0, 0, 0, 0, 12'h0, 32'h0, 1);
        rst = 1'b1;
        m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1;
        #3 check_reset_outs("reset_mid_read");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        cyc(1, 1, 0, 12'h400, 32'h40, 1, 1, 0, 12'h401, 32'h41, 1);
        cyc(0, 0, 0, 12'h0, 32'h0, 1, 1, 0, 12'h401, 32'h41, 2);

        // M0 lock with one idle cycle blocks M1
        cyc(1, 1, 1, 12'h500, 32'h11, 1, 1, 0, 12'h501, 32'h66, 1);
        cyc(0, 0, 1, 12'h0, 32'h0, 1, 1, 0, 12'h501, 32'h66, 0);
        cyc(1, 1, 1, 12'h502, 32'h22, 1, 1, 0, 12'h501, 32'h66, 1);
        cyc(1, 1, 0, 12'h503, 32'h33, 1, 1, 0, 12'h501, 32'h66, 1);
        cyc(0, 0, 0, 12'h0, 32'h0, 1, 1, 0, 12'h501, 32'h66, 2);
        idle(2);

        check("gq_drained", 64'(gq.size()), 64'd0);
        check("rq0_drained", 64'(rq0.size()), 64'd0);
        check("rq1_drained", 64'(rq1.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
